ps2_host_tx: RTL

Host-to-device PS/2 transmitter. It sends command bytes to the keyboard, such as 0xED for LED set, 0xF3 for typematic rate and 0xFF for reset. It is the counterpart of the existing PS/2 receive path, which delivers scan codes via ps2_data/ps2_hit. The port controller drives it through a write-only command port and a status bit. It drives the shared open-drain PS/2 clock and data lines and tells the receiver to ignore line activity while a transmission is in progress.

---
 rtl/ps2_pkg.sv | 29 ++
 rtl/ps2_line_sync.sv | 63 ++++++
 rtl/ps2_host_tx.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 host-side blocks.
//   state_t      - host transmit FSM states
//   DATA_BITS    - payload bits per frame
//   STOP_IDX     - bit counter value at which the stop bit is due
//   DEF_*        - default timing/filter parameters (25 MHz system clock)
//   odd_parity() - parity bit that makes data+parity carry an odd number of ones
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    SEND,
    ACK,
    WAIT_IDLE,
    DONE
  } state_t;

  localparam int DATA_BITS = 8;
  localparam int STOP_IDX  = 9;

  localparam int DEF_INHIBIT_CYCLES = 2500;    // 100 us
  localparam int DEF_TIMEOUT_CYCLES = 375000;  // 15 ms
  localparam int DEF_FILTER_LEN     = 4;

  function automatic logic odd_parity(input logic [DATA_BITS-1:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: conditions one raw PS/2 pin (clock or data).
//   clock, resetn - system clock, synchronous active-low reset
//   line_i        - raw asynchronous pin level
//   level_o       - filtered level; changes only after FILTER_LEN equal samples
//   fall_o        - one-cycle pulse after level_o goes 1 -> 0
// The idle bus level is high, so every stage presets to 1.
module ps2_line_sync
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = DEF_FILTER_LEN
) (
  input  logic clock,
  input  logic resetn,
  input  logic line_i,
  output logic level_o,
  output logic fall_o
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic          meta_q, meta_d;
  logic          sync_q, sync_d;
  logic          level_q, level_d;
  logic          prev_q, prev_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    meta_d  = line_i;
    sync_d  = meta_q;
    prev_d  = level_q;
    level_d = level_q;
    cnt_d   = '0;
    // cnt_q counts how many consecutive samples have already disagreed
    // with the accepted level; the FILTER_LEN-th one flips it.
    if (sync_q != level_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) begin
        level_d = sync_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      level_q <= 1'b1;
      prev_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      meta_q  <= meta_d;
      sync_q  <= sync_d;
      level_q <= level_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign fall_o  = prev_q & ~level_q;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
//   clock, resetn          - system clock, synchronous active-low reset
//   tx_data, tx_start      - command byte and one-cycle request (taken when idle)
//   tx_busy, tx_done       - transfer in progress / one-cycle end-of-transfer pulse
//   tx_ack_err, tx_timeout - result flags, held until the next accepted start
//   rx_inhibit             - tells the receive path to ignore line activity
//   ps2_clk_i, ps2_dat_i   - raw open-drain pin levels
//   ps2_clk_oe, ps2_dat_oe - 1 pulls the pin low, 0 releases it
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | lines released, waiting for tx_start
// INHIBIT   | holding clock low for INHIBIT_CYCLES (request-to-send)
// SEND      | clocking out data[0..7], parity, then releasing for stop
// ACK       | waiting for the device clock that carries the ACK bit
// WAIT_IDLE | waiting for both lines to return high
// DONE      | one-cycle completion pulse
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int FILTER_LEN     = DEF_FILTER_LEN
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_start,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 tx_ack_err,
  output logic                 tx_timeout,
  output logic                 rx_inhibit,
  input  logic                 ps2_clk_i,
  input  logic                 ps2_dat_i,
  output logic                 ps2_clk_oe,
  output logic                 ps2_dat_oe
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INHIBIT_LOAD = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       STOP_BIT     = 4'(STOP_IDX);

  state_t               state_q, state_d;
  logic [DATA_BITS:0]   shift_q, shift_d;
  logic [3:0]           bitcnt_q, bitcnt_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 clk_oe_q, clk_oe_d;
  logic                 dat_oe_q, dat_oe_d;
  logic                 ack_err_q, ack_err_d;
  logic                 timeout_q, timeout_d;

  logic clk_level, clk_fall;
  logic dat_level, dat_fall_unused;

  ps2_line_sync #(.FILTER_LEN(FILTER_LEN)) u_clk_sync (
    .clock   (clock),
    .resetn  (resetn),
    .line_i  (ps2_clk_i),
    .level_o (clk_level),
    .fall_o  (clk_fall)
  );

  ps2_line_sync #(.FILTER_LEN(FILTER_LEN)) u_dat_sync (
    .clock   (clock),
    .resetn  (resetn),
    .line_i  (ps2_dat_i),
    .level_o (dat_level),
    .fall_o  (dat_fall_unused)
  );

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bitcnt_q  <= '0;
      cnt_q     <= '0;
      clk_oe_q  <= 1'b0;
      dat_oe_q  <= 1'b0;
      ack_err_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bitcnt_q  <= bitcnt_d;
      cnt_q     <= cnt_d;
      clk_oe_q  <= clk_oe_d;
      dat_oe_q  <= dat_oe_d;
      ack_err_q <= ack_err_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bitcnt_d  = bitcnt_q;
    cnt_d     = cnt_q;
    clk_oe_d  = clk_oe_q;
    dat_oe_d  = dat_oe_q;
    ack_err_d = ack_err_q;
    timeout_d = timeout_q;
    case (state_q)
      IDLE: begin
        if (tx_start) begin
          shift_d   = {odd_parity(tx_data), tx_data};
          ack_err_d = 1'b0;
          timeout_d = 1'b0;
          clk_oe_d  = 1'b1;
          dat_oe_d  = 1'b0;
          cnt_d     = INHIBIT_LOAD;
          state_d   = INHIBIT;
        end
      end
      INHIBIT: begin
        if (cnt_q == '0) begin
          // Start bit and clock release land together.
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b1;
          bitcnt_d = '0;
          cnt_d    = TIMEOUT_LOAD;
          state_d  = SEND;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      SEND, ACK, WAIT_IDLE: begin
        // One budget spans the whole device-clocked phase; expiry beats
        // any line event seen in the same cycle.
        if (cnt_q == '0) begin
          clk_oe_d  = 1'b0;
          dat_oe_d  = 1'b0;
          timeout_d = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
          case (state_q)
            SEND: begin
              if (clk_fall) begin
                if (bitcnt_q == STOP_BIT) begin
                  dat_oe_d = 1'b0;
                  state_d  = ACK;
                end else begin
                  dat_oe_d = ~shift_q[bitcnt_q];
                end
                bitcnt_d = bitcnt_q + 1'b1;
              end
            end
            ACK: begin
              if (clk_fall) begin
                ack_err_d = dat_level;
                state_d   = WAIT_IDLE;
              end
            end
            default: begin
              if (clk_level && dat_level) begin
                state_d = DONE;
              end
            end
          endcase
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d  = IDLE;
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    tx_busy    = 1'b1;
    rx_inhibit = 1'b1;
    tx_done    = 1'b0;
    case (state_q)
      IDLE: begin
        tx_busy    = 1'b0;
        rx_inhibit = 1'b0;
      end
      DONE:    tx_done = 1'b1;
      default: ;
    endcase
  end

  assign tx_ack_err = ack_err_q;
  assign tx_timeout = timeout_q;
  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;

endmodule
